// File: rtl/spi_cmd_sequencer_pkg.sv
// Shared definitions for the SPI command sequencer: opcode classes, FSM states, packet fields.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package spi_cmd_pkg;

  localparam logic [3:0] CLS_NOP    = 4'h0;
  localparam logic [3:0] CLS_REG    = 4'h1;
  localparam logic [3:0] CLS_VERTEX = 4'h2;
  localparam logic [3:0] CLS_DRAW   = 4'h3;
  localparam logic [3:0] CLS_VAR    = 4'hF;

  // Marker bit positions inside fifo_data; byte occupies [7:0].
  localparam int FIRST_BIT = 8;
  localparam int LAST_BIT  = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_DISCARD
  } state_t;

  typedef struct packed {
    logic       known;
    logic [7:0] len;
  } cls_info_t;

  // Payload length of fixed-length opcode classes; VAR and unknown classes report known=0.
  function automatic cls_info_t class_info(input logic [3:0] cls);
    cls_info_t info;
    info.known = 1'b1;
    info.len   = 8'd0;
    case (cls)
      CLS_NOP:    info.len = 8'd0;
      CLS_REG:    info.len = 8'd2;
      CLS_VERTEX: info.len = 8'd6;
      CLS_DRAW:   info.len = 8'd1;
      default:    info.known = 1'b0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/spi_cmd_sequencer_if.sv
// Command FIFO write port: framed bytes out, full and frame abort alongside.
// Latency: n/a (wiring only).
// Backpressure: fifo_full is a level; the producer drops and flags, it never stalls.
interface spi_cmd_sequencer_if;
  logic       fifo_full;
  logic       fifo_wr;
  logic [9:0] fifo_data;
  logic       frame_abort;

  modport master (input fifo_full, output fifo_wr, output fifo_data, output frame_abort);
  modport slave  (output fifo_full, input fifo_wr, input fifo_data, input frame_abort);
endinterface

// File: rtl/spi_cmd_sequencer_byte_shifter.sv
// Bit counter and MSB-first shifter; flags the edge that completes a byte.
// Latency: byte_valid/rx_byte are combinational on the 8th sampling edge.
// Backpressure: none; spi_cs low discards any partially shifted byte.
module spi_byte_shifter (
  input  logic       spi_clk,
  input  logic       rst,
  input  logic       spi_cs,
  input  logic       spi_data,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       cs_low
);

  logic [2:0] bit_cnt;
  logic [6:0] shift;

  // Count and shift bits while selected; restart the byte whenever spi_cs is low.
  always_ff @(posedge spi_clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= 3'd0;
      shift   <= 7'd0;
    end else if (!spi_cs) begin
      bit_cnt <= 3'd0;
    end else begin
      bit_cnt <= bit_cnt + 3'd1;
      shift   <= {shift[5:0], spi_data};
    end
  end

  assign byte_valid = spi_cs && (bit_cnt == 3'd7);
  assign rx_byte    = {shift, spi_data};
  assign cs_low     = !spi_cs;

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Frames the MOSI stream into first/last-tagged command bytes for the command FIFO.
// Latency: one spi_clk after the 8th bit edge (fifo_wr/fifo_data registered).
// Backpressure: a byte completing while fifo_full is dropped, flagged, and the frame discarded.
module spi_cmd_sequencer
  import spi_cmd_pkg::*;
#(
  parameter int VAR_MAX = 64
) (
  input  logic spi_clk,
  input  logic rst,
  input  logic spi_cs,
  input  logic spi_data,
  input  logic err_clear,
  output logic err_opcode,
  output logic err_overflow,
  spi_cmd_sequencer_if.master fifo
);

  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       cs_low;

  state_t     state, state_n;
  logic [7:0] remaining, remaining_n;
  logic       wr_n, abort_n, set_opcode, set_overflow;
  logic [9:0] dat_n;
  cls_info_t  info;
  logic       in_cmd;

  spi_byte_shifter u_shifter (
    .spi_clk    (spi_clk),
    .rst        (rst),
    .spi_cs     (spi_cs),
    .spi_data   (spi_data),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .cs_low     (cs_low)
  );

  assign info   = class_info(rx_byte[7:4]);
  assign in_cmd = (state == ST_LEN) || (state == ST_PAYLOAD);

  // Next state and next registered outputs from the completed byte, spi_cs and fifo_full.
  always_comb begin
    state_n      = state;
    remaining_n  = remaining;
    wr_n         = 1'b0;
    dat_n        = '0;
    abort_n      = 1'b0;
    set_opcode   = 1'b0;
    set_overflow = 1'b0;
    if (cs_low) begin
      abort_n = in_cmd;
      state_n = ST_IDLE;
    end else if (byte_valid && state != ST_DISCARD) begin
      if (fifo.fifo_full) begin
        set_overflow = 1'b1;
        abort_n      = in_cmd;
        state_n      = ST_DISCARD;
      end else begin
        dat_n[7:0] = rx_byte;
        case (state)
          ST_IDLE: begin
            if (rx_byte[7:4] == CLS_VAR) begin
              wr_n             = 1'b1;
              dat_n[FIRST_BIT] = 1'b1;
              state_n          = ST_LEN;
            end else if (info.known) begin
              wr_n             = 1'b1;
              dat_n[FIRST_BIT] = 1'b1;
              if (info.len == 8'd0) begin
                dat_n[LAST_BIT] = 1'b1;
              end else begin
                remaining_n = info.len;
                state_n     = ST_PAYLOAD;
              end
            end else begin
              set_opcode = 1'b1;
              state_n    = ST_DISCARD;
            end
          end
          ST_LEN: begin
            if (int'(rx_byte) > VAR_MAX) begin
              set_opcode = 1'b1;
              abort_n    = 1'b1;
              state_n    = ST_DISCARD;
            end else begin
              wr_n = 1'b1;
              if (rx_byte == 8'd0) begin
                dat_n[LAST_BIT] = 1'b1;
                state_n         = ST_IDLE;
              end else begin
                remaining_n = rx_byte;
                state_n     = ST_PAYLOAD;
              end
            end
          end
          ST_PAYLOAD: begin
            wr_n        = 1'b1;
            remaining_n = remaining - 8'd1;
            if (remaining == 8'd1) begin
              dat_n[LAST_BIT] = 1'b1;
              state_n         = ST_IDLE;
            end
          end
          default: ;
        endcase
        if (!wr_n) dat_n = '0;
      end
    end
  end

  // State, registered outputs and sticky errors; a set on the clear edge wins.
  always_ff @(posedge spi_clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      remaining        <= 8'd0;
      fifo.fifo_wr     <= 1'b0;
      fifo.fifo_data   <= '0;
      fifo.frame_abort <= 1'b0;
      err_opcode       <= 1'b0;
      err_overflow     <= 1'b0;
    end else begin
      state            <= state_n;
      remaining        <= remaining_n;
      fifo.fifo_wr     <= wr_n;
      fifo.fifo_data   <= dat_n;
      fifo.frame_abort <= abort_n;
      err_opcode       <= (err_opcode & ~err_clear) | set_opcode;
      err_overflow     <= (err_overflow & ~err_clear) | set_overflow;
    end
  end

endmodule
